// File: rtl/apb_regfile_slave.sv
// APB completer: bank of NUM_REGS 32-bit R/W registers, byte strobes, slverr.
// Define APB_WAIT_STATE_EN to insert one wait state per transfer.
module apb_regfile_slave #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 4
) (
  input  logic                    PCLK,
  input  logic                    PRESETn,
  input  logic                    PSEL,
  input  logic                    PENABLE,
  input  logic                    PWRITE,
  input  logic [ADDR_WIDTH-1:0]   PADDR,
  input  logic [DATA_WIDTH-1:0]   PWDATA,
  input  logic [DATA_WIDTH/8-1:0] PSTRB,
  output logic [DATA_WIDTH-1:0]   PRDATA,
  output logic                    PREADY,
  output logic                    PSLVERR
);

  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int WA_W  = ADDR_WIDTH - 2;
  localparam int NB    = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACCESS
  } state_t;

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
  logic [IDX_W-1:0]      r_idx;
  logic                  r_valid;
  logic                  r_write;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_ready;
  logic                  r_slverr;

  logic                  w_setup;
  logic                  w_access;
  logic [WA_W-1:0]       w_word;
  logic                  w_valid;
  logic [IDX_W-1:0]      w_idx;
  logic [IDX_W-1:0]      w_rd_idx;
  logic [DATA_WIDTH-1:0] w_rd_data;
  logic [DATA_WIDTH-1:0] w_wmask;
  logic                  w_commit;

  assign PRDATA  = r_rdata;
  assign PREADY  = r_ready;
  assign PSLVERR = r_slverr;

  assign w_setup  = PSEL & ~PENABLE;
  assign w_access = PSEL & PENABLE;
  assign w_word   = PADDR[ADDR_WIDTH-1:2];
  assign w_valid  = (PADDR[1:0] == 2'b00) &&
                    (w_word < WA_W'(NUM_REGS));
  assign w_idx    = w_word[IDX_W-1:0];

`ifdef APB_WAIT_STATE_EN
  assign w_rd_idx = r_idx;
`else
  assign w_rd_idx = w_idx;
`endif

  assign w_commit = (r_state == ST_ACCESS) && w_access &&
                    r_write && r_valid;

  // Read mux over the bank; out-of-range index reads zero
  always_comb begin
    w_rd_data = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (w_rd_idx == IDX_W'(i)) w_rd_data = r_regs[i];
    end
  end

  // Expand byte strobes to a bit mask
  always_comb begin
    w_wmask = '0;
    for (int n = 0; n < NB; n++) begin
      w_wmask[8*n +: 8] = {8{PSTRB[n]}};
    end
  end

  // Transfer FSM: decode in setup, registered ready/err/rdata
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state  <= ST_IDLE;
      r_idx    <= '0;
      r_valid  <= 1'b0;
      r_write  <= 1'b0;
      r_rdata  <= '0;
      r_ready  <= 1'b0;
      r_slverr <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_setup) begin
            r_idx   <= w_idx;
            r_valid <= w_valid;
            r_write <= PWRITE;
`ifdef APB_WAIT_STATE_EN
            r_state <= ST_WAIT;
`else
            r_state  <= ST_ACCESS;
            r_ready  <= 1'b1;
            r_slverr <= ~w_valid;
            r_rdata  <= (w_valid && !PWRITE) ? w_rd_data : '0;
`endif
          end
        end
        ST_WAIT: begin
          if (w_access) begin
            r_state  <= ST_ACCESS;
            r_ready  <= 1'b1;
            r_slverr <= ~r_valid;
            r_rdata  <= (r_valid && !r_write) ? w_rd_data : '0;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_ACCESS: begin
          r_state  <= ST_IDLE;
          r_ready  <= 1'b0;
          r_slverr <= 1'b0;
          r_rdata  <= '0;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Register bank: strobed byte write on the completing edge
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else if (w_commit) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (r_idx == IDX_W'(i)) begin
          r_regs[i] <= (r_regs[i] & ~w_wmask) |
                       (PWDATA & w_wmask);
        end
      end
    end
  end

endmodule

// File: tb/tb_apb_regfile_slave.sv
// Directed bench for apb_regfile_slave.
// Define APB_WAIT_STATE_EN to check the one-wait-state build.
module tb_apb_regfile_slave;

`ifdef APB_WAIT_STATE_EN
  localparam int CYC = 2;
`else
  localparam int CYC = 1;
`endif

  logic        PCLK;
  logic        PRESETn;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic [3:0]  PSTRB;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  int checks = 0;
  int errors = 0;

  apb_regfile_slave #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .NUM_REGS  (4)
  ) dut (
    .PCLK   (PCLK),
    .PRESETn(PRESETn),
    .PSEL   (PSEL),
    .PENABLE(PENABLE),
    .PWRITE (PWRITE),
    .PADDR  (PADDR),
    .PWDATA (PWDATA),
    .PSTRB  (PSTRB),
    .PRDATA (PRDATA),
    .PREADY (PREADY),
    .PSLVERR(PSLVERR)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Entered and left at posedge+1; no idle inserted
  task automatic xfer(input logic wr,
                      input logic [31:0] a,
                      input logic [31:0] wd,
                      input logic [3:0] st,
                      output logic [31:0] rd,
                      output logic err,
                      output int cyc);
    PSEL    = 1'b1;
    PENABLE = 1'b0;
    PWRITE  = wr;
    PADDR   = a;
    PWDATA  = wd;
    PSTRB   = st;
    rd  = '0;
    err = 1'b0;
    cyc = 0;
    @(negedge PCLK);
    check("setup_ready", 32'(PREADY), 32'd0);
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge PCLK);
      if (PREADY) begin
        rd  = PRDATA;
        err = PSLVERR;
        cyc = k;
        @(posedge PCLK); #1;
        break;
      end
      @(posedge PCLK); #1;
    end
  endtask

  task automatic rd_chk(input logic [31:0] a,
                        input logic [31:0] exp,
                        input logic experr);
    logic [31:0] d;
    logic        e;
    int          c;
    xfer(1'b0, a, 32'h0, 4'h0, d, e, c);
    check($sformatf("rd_data@%h", a), d, exp);
    check($sformatf("rd_err@%h", a), 32'(e), 32'(experr));
    check($sformatf("rd_cyc@%h", a), 32'(c), 32'(CYC));
  endtask

  task automatic wr_chk(input logic [31:0] a,
                        input logic [31:0] wd,
                        input logic [3:0] st,
                        input logic experr);
    logic [31:0] d;
    logic        e;
    int          c;
    xfer(1'b1, a, wd, st, d, e, c);
    check($sformatf("wr_err@%h", a), 32'(e), 32'(experr));
    check($sformatf("wr_cyc@%h", a), 32'(c), 32'(CYC));
    if (experr) check($sformatf("wr_errdata@%h", a), d, 32'h0);
  endtask

  task automatic idle();
    PSEL    = 1'b0;
    PENABLE = 1'b0;
    @(negedge PCLK);
    check("idle_ready", 32'(PREADY), 32'd0);
    check("idle_err", 32'(PSLVERR), 32'd0);
    check("idle_rdata", PRDATA, 32'h0);
    @(posedge PCLK); #1;
  endtask

  initial begin
    PRESETn = 1'b0;
    PSEL    = 1'b0;
    PENABLE = 1'b0;
    PWRITE  = 1'b0;
    PADDR   = '0;
    PWDATA  = '0;
    PSTRB   = '0;
    repeat (3) @(posedge PCLK);
    @(negedge PCLK);
    check("rst_ready", 32'(PREADY), 32'd0);
    check("rst_err", 32'(PSLVERR), 32'd0);
    check("rst_rdata", PRDATA, 32'h0);
    PRESETn = 1'b1;
    @(posedge PCLK); #1;

    rd_chk(32'h0, 32'h0, 1'b0);
    rd_chk(32'h4, 32'h0, 1'b0);
    rd_chk(32'h8, 32'h0, 1'b0);
    rd_chk(32'hC, 32'h0, 1'b0);
    idle();

    wr_chk(32'h0, 32'h0000_0011, 4'hF, 1'b0);
    idle();
    rd_chk(32'h0, 32'h0000_0011, 1'b0);
    idle();
    wr_chk(32'h4, 32'h0123_7A49, 4'hF, 1'b0);
    rd_chk(32'h4, 32'h0123_7A49, 1'b0);
    idle();

    wr_chk(32'h8, 32'h5473_7962, 4'hF, 1'b0);
    wr_chk(32'hC, 32'h416E_6173, 4'hF, 1'b0);
    rd_chk(32'h8, 32'h5473_7962, 1'b0);
    rd_chk(32'hC, 32'h416E_6173, 1'b0);
    rd_chk(32'h0, 32'h0000_0011, 1'b0);
    rd_chk(32'h4, 32'h0123_7A49, 1'b0);
    idle();

    wr_chk(32'h0, 32'hFFFF_FFFF, 4'b0010, 1'b0);
    rd_chk(32'h0, 32'h0000_FF11, 1'b0);
    wr_chk(32'h0, 32'hAAAA_AAAA, 4'b0000, 1'b0);
    rd_chk(32'h0, 32'h0000_FF11, 1'b0);
    idle();

    wr_chk(32'h10, 32'hDEAD_BEEF, 4'hF, 1'b1);
    rd_chk(32'h10, 32'h0, 1'b1);
    wr_chk(32'h2, 32'hCAFE_F00D, 4'hF, 1'b1);
    rd_chk(32'h2, 32'h0, 1'b1);
    rd_chk(32'h0, 32'h0000_FF11, 1'b0);
    rd_chk(32'h4, 32'h0123_7A49, 1'b0);
    rd_chk(32'h8, 32'h5473_7962, 1'b0);
    rd_chk(32'hC, 32'h416E_6173, 1'b0);
    idle();

    // Reset asserted in the access phase of a write
    PSEL    = 1'b1;
    PENABLE = 1'b0;
    PWRITE  = 1'b1;
    PADDR   = 32'h4;
    PWDATA  = 32'h1234_5678;
    PSTRB   = 4'hF;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    #2;
    PRESETn = 1'b0;
    #1;
    check("arst_ready", 32'(PREADY), 32'd0);
    check("arst_err", 32'(PSLVERR), 32'd0);
    check("arst_rdata", PRDATA, 32'h0);
    @(posedge PCLK); #1;
    @(negedge PCLK);
    PRESETn = 1'b1;
    @(negedge PCLK);
    check("post_rst_ready", 32'(PREADY), 32'd0);
    @(posedge PCLK); #1;
    idle();
    rd_chk(32'h0, 32'h0, 1'b0);
    rd_chk(32'h4, 32'h0, 1'b0);
    rd_chk(32'h8, 32'h0, 1'b0);
    rd_chk(32'hC, 32'h0, 1'b0);
    idle();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
